// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       retire;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] state;

  // Controller side
  modport master (
    input  opcode, func, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, retire,
           trap, trap_cause, state
  );

  // Datapath side
  modport slave (
    output opcode, func, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, retire,
           trap, trap_cause, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready handshake, timeout and trap.
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned MEM_TIMEOUT   = 16
) (
  input logic                    clock,
  input logic                    reset_n,
  mips_multicycle_ctrl_if.master bus
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic HS_EN = (MEM_HANDSHAKE != 0);
  localparam logic TO_EN = (MEM_HANDSHAKE != 0) && (MEM_TIMEOUT != 0);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_I_EXEC   = 4'd8;
  localparam logic [3:0] S_I_WB     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_JR       = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             ready, in_wait, timeout_hit;

  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic       alu_src_a, retire, trap;

  assign ready       = bus.mem_ready | ~HS_EN;
  assign in_wait     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout_hit = TO_EN && !ready && (cnt_q == CNT_LAST);

  // State, wait counter and trap cause registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next-state, wait counter and control decode
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    retire     = 1'b0;
    trap       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        state_d   = S_TRAP;
        cause_d   = CAUSE_ILLEGAL;
        case (bus.opcode)
          OP_LW, OP_SW: begin state_d = S_MEM_ADDR; cause_d = cause_q; end
          OP_ADDI, OP_ANDI: begin state_d = S_I_EXEC; cause_d = cause_q; end
          OP_BEQ: begin state_d = S_BRANCH; cause_d = cause_q; end
          OP_J, OP_JAL: begin state_d = S_JUMP; cause_d = cause_q; end
          OP_RTYPE: begin
            if (bus.func == FN_JR) begin
              state_d = S_JR;
              cause_d = cause_q;
            end else if (bus.func inside {FN_ADD, FN_AND, FN_NOR, FN_SLT, FN_SLL}) begin
              state_d = S_R_EXEC;
              cause_d = cause_q;
            end
          end
          default: ;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (ready) begin
          state_d = S_MEM_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (bus.opcode == OP_ANDI) ? 2'b11 : 2'b00;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_en     = bus.zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        if (bus.opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      S_JR: begin
        pc_source = 2'b11;
        pc_en     = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Counter runs only while lingering in a memory wait state
    cnt_d = (in_wait && !ready && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;
  end

  // Everything reads as zero while reset is held
  assign bus.pc_en      = reset_n & pc_en;
  assign bus.iord       = reset_n & iord;
  assign bus.mem_read   = reset_n & mem_read;
  assign bus.mem_write  = reset_n & mem_write;
  assign bus.ir_write   = reset_n & ir_write;
  assign bus.reg_write  = reset_n & reg_write;
  assign bus.reg_dst    = reset_n ? reg_dst : 2'b00;
  assign bus.mem_to_reg = reset_n ? mem_to_reg : 2'b00;
  assign bus.alu_src_a  = reset_n & alu_src_a;
  assign bus.alu_src_b  = reset_n ? alu_src_b : 2'b00;
  assign bus.alu_op     = reset_n ? alu_op : 2'b00;
  assign bus.pc_source  = reset_n ? pc_source : 2'b00;
  assign bus.retire     = reset_n & retire;
  assign bus.trap       = reset_n & trap;
  assign bus.trap_cause = reset_n ? cause_q : 2'b00;
  assign bus.state      = reset_n ? state_q : 4'd0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench: directed vector table, timeout sequences and randomized model check
// across three parameterisations sharing one set of inputs.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       retire, trap;
    logic [1:0] trap_cause;
    logic [3:0] state;
  } outs_t;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_en, ir_write, reg_write, retire;
    logic [1:0] reg_dst, mem_to_reg, pc_source, trap_cause;
  } view_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       z, rdy;
    view_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, func;
  logic       zero, mem_ready;
  outs_t      dout [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned HS = (g == 2) ? 0 : 1;
    localparam int unsigned TO = (g == 1) ? 4 : 16;
    assign bus[g].opcode    = opcode;
    assign bus[g].func      = func;
    assign bus[g].zero      = zero;
    assign bus[g].mem_ready = mem_ready;
    assign dout[g] = {bus[g].pc_en, bus[g].iord, bus[g].mem_read, bus[g].mem_write,
                      bus[g].ir_write, bus[g].reg_write, bus[g].reg_dst, bus[g].mem_to_reg,
                      bus[g].alu_src_a, bus[g].alu_src_b, bus[g].alu_op, bus[g].pc_source,
                      bus[g].retire, bus[g].trap, bus[g].trap_cause, bus[g].state};
    mips_multicycle_ctrl #(.MEM_HANDSHAKE(HS), .MEM_TIMEOUT(TO)) u_dut (
      .clock  (clk),
      .reset_n(rst_n),
      .bus    (bus[g])
    );
  end

  function automatic view_t view(outs_t o);
    return {o.state, o.pc_en, o.ir_write, o.reg_write, o.retire,
            o.reg_dst, o.mem_to_reg, o.pc_source, o.trap_cause};
  endfunction

  task automatic chk(string name, int k, int unsigned got, int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d t=%0t got %0h want %0h", name, k, $time, got, exp);
    end
  endtask

  task automatic drv(logic [5:0] op, logic [5:0] fn, logic z, logic rdy);
    opcode = op; func = fn; zero = z; mem_ready = rdy;
  endtask

  // Hold reset two cycles with ready high; every output must read zero
  task automatic apply_reset(string tag);
    rst_n = 1'b0;
    drv(6'h00, 6'h20, 1'b1, 1'b1);
    #1;
    for (int k = 0; k < 3; k++) chk({tag, "_rst_zero"}, k, 32'(dout[k]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
  endtask

  // ---------------- reference model: per-instruction phase lists ----------------
  int         m_hs [3] = '{1, 1, 0};
  int         m_to [3] = '{16, 4, 16};
  int         m_cur [3];
  int         m_wc [3];
  int         m_q [3][3];
  int         m_qn [3];
  logic [1:0] m_cause [3];
  logic [5:0] m_op [3];

  function automatic void m_reset(int k);
    m_cur[k] = 0; m_wc[k] = 0; m_qn[k] = 0; m_cause[k] = 2'b00;
  endfunction

  function automatic void m_push(int k, int s);
    m_q[k][m_qn[k]] = s;
    m_qn[k]++;
  endfunction

  function automatic int m_pop(int k);
    int s;
    if (m_qn[k] == 0) return 0;
    s = m_q[k][0];
    m_q[k][0] = m_q[k][1];
    m_q[k][1] = m_q[k][2];
    m_qn[k]--;
    return s;
  endfunction

  // Phase list for the instruction sitting in IR
  function automatic int m_decode(int k);
    m_op[k] = opcode;
    m_qn[k] = 0;
    if (opcode == 6'h23) begin m_push(k, 2); m_push(k, 3); m_push(k, 4); end
    else if (opcode == 6'h2B) begin m_push(k, 2); m_push(k, 5); end
    else if (opcode == 6'h08 || opcode == 6'h0C) begin m_push(k, 8); m_push(k, 9); end
    else if (opcode == 6'h04) m_push(k, 10);
    else if (opcode == 6'h02 || opcode == 6'h03) m_push(k, 11);
    else if (opcode == 6'h00) begin
      if (func == 6'h08) m_push(k, 12);
      else if (func == 6'h20 || func == 6'h24 || func == 6'h27 || func == 6'h2A || func == 6'h00) begin
        m_push(k, 6); m_push(k, 7);
      end
    end
    if (m_qn[k] == 0) begin
      m_cause[k] = 2'b01;
      return 13;
    end
    return m_pop(k);
  endfunction

  function automatic outs_t m_out(int k);
    outs_t o = '0;
    logic  rdy = (m_hs[k] != 0) ? mem_ready : 1'b1;
    o.state      = 4'(m_cur[k]);
    o.trap_cause = m_cause[k];
    case (m_cur[k])
      0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy; end
      1:  o.alu_src_b = 2'b11;
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3:  begin o.mem_read = 1; o.iord = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 2'b01; o.retire = 1; end
      5:  begin o.mem_write = 1; o.iord = 1; o.retire = rdy; end
      6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      7:  begin o.reg_write = 1; o.reg_dst = 2'b01; o.retire = 1; end
      8:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = (m_op[k] == 6'h0C) ? 2'b11 : 2'b00; end
      9:  begin o.reg_write = 1; o.retire = 1; end
      10: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_en = zero; o.retire = 1; end
      11: begin
        o.pc_source = 2'b10; o.pc_en = 1; o.retire = 1;
        if (m_op[k] == 6'h03) begin o.reg_write = 1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; end
      end
      12: begin o.pc_source = 2'b11; o.pc_en = 1; o.retire = 1; end
      13: o.trap = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic void m_step(int k);
    int   nxt = m_cur[k];
    logic rdy = (m_hs[k] != 0) ? mem_ready : 1'b1;
    case (m_cur[k])
      13: ;
      0, 3, 5: begin
        if (rdy) nxt = (m_cur[k] == 0) ? 1 : m_pop(k);
        else if (m_hs[k] != 0 && m_to[k] > 0 && m_wc[k] == m_to[k] - 1) begin
          nxt = 13;
          m_cause[k] = 2'b10;
        end
      end
      1: nxt = m_decode(k);
      default: nxt = m_pop(k);
    endcase
    if (nxt == m_cur[k] && nxt != 13) m_wc[k]++;
    else m_wc[k] = 0;
    m_cur[k] = nxt;
  endfunction

  function automatic logic ir_may_change();
    for (int k = 0; k < 3; k++)
      if (m_cur[k] == 1 || m_cur[k] == 2 || m_cur[k] == 8 || m_cur[k] == 11) return 1'b0;
    return 1'b1;
  endfunction

  // Row: op, fn, zero, ready | state pc_en ir_write reg_write retire reg_dst mem_to_reg pc_source cause
  function automatic vec_t mk(logic [5:0] op, logic [5:0] fn, logic z, logic rdy, logic [3:0] st,
                              logic pe, logic irw, logic rw, logic ret, logic [1:0] rd,
                              logic [1:0] m2r, logic [1:0] pcs, logic [1:0] cause);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
    v.exp = {st, pe, irw, rw, ret, rd, m2r, pcs, cause};
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    int           sel;
    logic [5:0]   ops [12] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h04, 6'h02, 6'h03, 6'h3F, 6'h11};
    logic [5:0]   fns [7]  = '{6'h20, 6'h24, 6'h27, 6'h2A, 6'h00, 6'h08, 6'h05};

    // add: 0,1,6,7
    tbl.push_back(mk(6'h00, 6'h20, 0, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h00, 6'h20, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h00, 6'h20, 0, 1, 6,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h00, 6'h20, 0, 1, 7,  0, 0, 1, 1, 2'b01, 2'b00, 2'b00, 2'b00));
    // lw: 3 fetch waits, 2 read waits, 10 cycles total
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(6'h23, 6'h00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h23, 6'h00, 0, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h23, 6'h00, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h23, 6'h00, 0, 0, 2,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(6'h23, 6'h00, 0, 0, 3, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h23, 6'h00, 0, 1, 3,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h23, 6'h00, 0, 1, 4,  0, 0, 1, 1, 2'b00, 2'b01, 2'b00, 2'b00));
    // beq taken then not taken
    for (int t = 1; t >= 0; t--) begin
      tbl.push_back(mk(6'h04, 6'h00, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk(6'h04, 6'h00, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk(6'h04, 6'h00, 1'(t), 1, 10, 1'(t), 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00));
    end
    // jal
    tbl.push_back(mk(6'h03, 6'h00, 0, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h03, 6'h00, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h03, 6'h00, 0, 1, 11, 1, 0, 1, 1, 2'b10, 2'b10, 2'b10, 2'b00));
    // jr
    tbl.push_back(mk(6'h00, 6'h08, 0, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h00, 6'h08, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h00, 6'h08, 0, 1, 12, 1, 0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b00));
    // illegal opcode traps and stays
    tbl.push_back(mk(6'h3F, 6'h00, 0, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h3F, 6'h00, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(6'h3F, 6'h00, 1, 1, 13, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(6'h23, 6'h00, 1, 1, 13, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01));

    rst_n = 1'b1;
    drv(6'h00, 6'h00, 1'b0, 1'b0);
    @(negedge clk);
    apply_reset("tbl");
    foreach (tbl[i]) begin
      drv(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rdy);
      #1;
      for (int k = 0; k < 2; k++) chk($sformatf("vec%0d", i), k, 32'(view(dout[k])), 32'(tbl[i].exp));
      if (tbl[i].exp.state == 4'd13) chk($sformatf("vec%0d_trap", i), 0, 32'(dout[0].trap), 32'd1);
      @(negedge clk);
    end

    // Leave trap by reset; afterwards handshake and no-handshake fetch differ on ready low
    apply_reset("trapexit");
    #1;
    chk("post_rst_state", 0, 32'(dout[0].state), 32'd0);
    chk("post_rst_cause", 0, 32'(dout[0].trap_cause), 32'd0);
    chk("hs_fetch_wait", 0, 32'(dout[0].ir_write), 32'd0);
    chk("nohs_fetch", 2, 32'(dout[2].ir_write), 32'd1);
    @(negedge clk);

    // Reset in the middle of a load abandons it (zero check in apply_reset)
    drv(6'h23, 6'h00, 0, 1); @(negedge clk);
    drv(6'h23, 6'h00, 0, 1); @(negedge clk);
    drv(6'h23, 6'h00, 0, 0); #1;
    chk("mid_lw_addr", 0, 32'(dout[0].state), 32'd2);
    @(negedge clk);
    apply_reset("midinstr");

    // sw times out after four wait cycles on the MEM_TIMEOUT=4 instance
    for (int run = 0; run < 2; run++) begin
      if (run == 1) apply_reset("to_run2");
      drv(6'h2B, 6'h00, 0, 1); #1;
      chk("to_fetch", 1, 32'(dout[1].state), 32'd0);
      @(negedge clk);
      drv(6'h2B, 6'h00, 0, 0); #1;
      chk("to_decode", 1, 32'(dout[1].state), 32'd1);
      @(negedge clk); #1;
      chk("to_addr", 1, 32'(dout[1].state), 32'd2);
      @(negedge clk);
      for (int w = 0; w < 4; w++) begin
        mem_ready = (run == 1 && w == 3);
        #1;
        chk($sformatf("to%0d_wr_w%0d_state", run, w), 1, 32'(dout[1].state), 32'd5);
        chk($sformatf("to%0d_wr_w%0d_retire", run, w), 1, 32'(dout[1].retire), 32'(run == 1 && w == 3));
        @(negedge clk);
      end
      mem_ready = 1'b0;
      #1;
      chk($sformatf("to%0d_after_state", run), 1, 32'(dout[1].state), (run == 0) ? 32'd13 : 32'd0);
      chk($sformatf("to%0d_after_cause", run), 1, 32'(dout[1].trap_cause), (run == 0) ? 32'd2 : 32'd0);
      chk($sformatf("to%0d_after_trap", run), 1, 32'(dout[1].trap), (run == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    // Randomized run against the phase-list model on all three instances
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst_n     = (cyc == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      zero      = 1'($urandom_range(0, 1));
      if (cyc == 0 || !rst_n || ir_may_change()) begin
        sel    = int'($urandom_range(0, 11));
        opcode = (sel == 11) ? 6'($urandom) : ops[sel];
        sel    = int'($urandom_range(0, 6));
        func   = (sel == 6) ? 6'($urandom) : fns[sel];
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) m_reset(k);
        chk("rand", k, 32'(dout[k]), rst_n ? 32'(m_out(k)) : 32'd0);
        if (rst_n) m_step(k);
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Control FSM for the multi-cycle generation of the MIPS core: one shared memory, with instruction register, MDR, A/B and ALUOut registers in the datapath.
- Supports the existing instruction set: add, and, nor, slt, sll, addi, andi, lw, sw, beq, jal, jr, plus j.
- New over the single-cycle control unit:
  - multi-cycle sequencing;
  - a memory ready handshake with a parametrised timeout;
  - an illegal-opcode/bus-error trap;
  - a retire pulse.

Parameters:
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = memory completes in one cycle and mem_ready is ignored
MEM_TIMEOUT, 16, maximum wait cycles per memory access before bus-error trap; 0 disables the timeout (ignored when MEM_HANDSHAKE=0)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
func  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
pc_en  out  1  PC load enable
iord  out  1  0 = memory address from PC, 1 = from ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_write  out  1  register file write
reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2
alu_op  out  2  00 = add, 01 = sub, 10 = per func, 11 = and
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump address, 11 = A
retire  out  1  one-cycle pulse on the final cycle of each instruction
trap  out  1  high while in TRAP
trap_cause  out  2  00 = none, 01 = illegal instruction, 10 = bus timeout
state  out  4  current state code, for debug

Behaviour:
Reset:
- reset_n low: state = FETCH, wait counter = 0, trap_cause = 00.
- All outputs are forced to 0 combinationally while reset_n is low.
- Reset asserted mid-instruction abandons that instruction immediately.

Output rules:
- Outputs are Moore decodes of state, except where marked "on ready" (Mealy, gated by mem_ready).
- Every output not listed for a state is 0.
- "ready" below means mem_ready=1, or MEM_HANDSHAKE=0.

States and transitions (codes 0-13):
- FETCH(0): mem_read=1, iord=0, a=0, b=01, op=00.
  - On ready: ir_write=1, pc_en=1, pc_source=00, then -> DECODE.
  - Otherwise stay.
- DECODE(1): a=0, b=11, op=00 (branch target into ALUOut).
  - lw/sw (100011/101011) -> MEM_ADDR
  - R-type (000000): func 001000 -> JR; func in {100000, 100100, 100111, 101010, 000000} -> R_EXEC; any other func -> TRAP (01)
  - addi (001000) / andi (001100) -> I_EXEC
  - beq (000100) -> BRANCH
  - j (000010) / jal (000011) -> JUMP
  - any other opcode -> TRAP (01)
- MEM_ADDR(2): a=1, b=10, op=00 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD(3): mem_read=1, iord=1; on ready -> MEM_WB.
- MEM_WB(4): reg_write=1, reg_dst=00, mem_to_reg=01, retire=1 -> FETCH.
- MEM_WR(5): mem_write=1, iord=1; on ready: retire=1 -> FETCH.
- R_EXEC(6): a=1, b=00, op=10 -> R_WB.
- R_WB(7): reg_write=1, reg_dst=01, mem_to_reg=00, retire=1 -> FETCH.
- I_EXEC(8): a=1, b=10; op=00 for addi, 11 for andi -> I_WB.
- I_WB(9): reg_write=1, reg_dst=00, mem_to_reg=00, retire=1 -> FETCH.
- BRANCH(10): a=1, b=00, op=01, pc_source=01, pc_en=zero (combinational), retire=1 -> FETCH.
- JUMP(11): pc_source=10, pc_en=1, retire=1 -> FETCH.
  - For jal additionally: reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4).
- JR(12): pc_source=11, pc_en=1, retire=1 -> FETCH.
- TRAP(13): trap=1; all strobes 0; trap_cause is held; the FSM stays in TRAP until reset.

Timeout (MEM_HANDSHAKE=1, MEM_TIMEOUT>0):
- The wait counter (width $clog2(MEM_TIMEOUT+1)) is cleared on entry to FETCH, MEM_RD and MEM_WR.
- It increments each cycle spent in those states with mem_ready=0.
- If mem_ready=0 in the cycle the counter equals MEM_TIMEOUT-1: -> TRAP with trap_cause=10; no ir_write, pc_en or reg_write occurs.
- If mem_ready=1 arrives on that same cycle, the access completes normally.

Latency in cycles, zero-wait memory:
- R/I-type: 4
- lw: 5
- sw: 4
- beq, j, jal, jr: 3

Test Plan:
- Zero-wait memory, MEM_HANDSHAKE=1, opcode 000000 / func 100000 -> states 0, 1, 6, 7; retire high in cycle 4 only; reg_dst=01; reg_write=1 only in R_WB.
- lw (100011) with mem_ready low 3 cycles in FETCH and 2 in MEM_RD -> total 10 cycles; ir_write pulses once, coincident with mem_ready; MEM_WB has mem_to_reg=01.
- beq with zero=1 -> pc_en=1, pc_source=01 in BRANCH; repeat with zero=0 -> pc_en=0; both retire in cycle 3.
- jal (000011) -> JUMP state with reg_dst=10, mem_to_reg=10, pc_source=10, pc_en=1; jr (func 001000) -> pc_source=11.
- Opcode 111111 -> TRAP, trap_cause=01 from the cycle after DECODE; outputs stay 0; reset_n low then high -> FETCH, trap_cause=00.
- MEM_TIMEOUT=4, mem_ready held low in MEM_WR -> TRAP with cause 10 after 4 wait cycles, no retire; rerun with mem_ready rising on the 4th wait cycle -> retire, FETCH.
